// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode type and data width for the arbitrated ALU
package alu_pkg;

    localparam int DW = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu4_datapath.sv
// rtl/alu4_datapath.sv - combinational 4-bit add/sub/and/or with carry-borrow out
module alu4_datapath
    import alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       sel,
    output logic [DW-1:0] y,
    output logic          cout
);

    logic [DW:0] res;

    // One extra result bit carries the add carry or the subtract borrow
    always_comb begin
        res = '0;
        case (sel)
            ALU_ADD: res = {1'b0, a} + {1'b0, b};
            ALU_SUB: res = {1'b0, a} - {1'b0, b};
            ALU_AND: res = {1'b0, a & b};
            ALU_OR:  res = {1'b0, a | b};
            default: res = '0;
        endcase
    end

    assign y    = res[DW-1:0];
    assign cout = res[DW];

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - N-requester arbiter sharing one ALU; ALU_ARB_RR_EN selects round-robin
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [DW*N_REQ-1:0]   req_a,
    input  logic [DW*N_REQ-1:0]   req_b,
    input  logic [2*N_REQ-1:0]    req_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DW-1:0]         rsp_y,
    output logic                  rsp_cout,
    output logic [IDW-1:0]        rsp_id
);

    logic           can_accept;
    logic           gnt_any;
    logic [IDW-1:0] gnt_idx;
    logic           xfer;
    logic [DW-1:0]  a_mux;
    logic [DW-1:0]  b_mux;
    logic [1:0]     sel_mux;
    logic [DW-1:0]  dp_y;
    logic           dp_cout;

    assign can_accept = !rsp_valid || rsp_ready;
    assign xfer       = !rst && can_accept && gnt_any;

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) begin
                cand = cand - (IDW+1)'(N_REQ);
            end
            if (!gnt_any && req_valid[cand[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IDW-1:0];
            end
        end
    end

    // Pointer remembers the last completed grant only
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= gnt_idx;
        end
    end
`else
    // Fixed priority: scanning downward lets the lowest valid index win
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
    end
`endif

    // One-hot accept strobe, only when the output register can take a result
    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Grant-indexed operand mux feeding the single shared datapath
    always_comb begin
        a_mux   = '0;
        b_mux   = '0;
        sel_mux = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_mux   = req_a[DW*i +: DW];
                b_mux   = req_b[DW*i +: DW];
                sel_mux = req_sel[2*i +: 2];
            end
        end
    end

    alu4_datapath u_datapath (
        .a    (a_mux),
        .b    (b_mux),
        .sel  (alu_op_t'(sel_mux)),
        .y    (dp_y),
        .cout (dp_cout)
    );

    // Output register: load on transfer, drop valid when consumed, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_y     <= dp_y;
            rsp_cout  <= dp_cout;
            rsp_id    <= gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_y;
    logic        rsp_cout;
    logic [1:0]  rsp_id;

    int total;
    int bad;

    // behavioural model state
    logic       m_valid;
    logic [3:0] m_y;
    logic       m_cout;
    logic [1:0] m_id;
    int         m_ptr;
    logic [3:0] exp_ready;
    logic [3:0] seen_ready;

    alu_arbiter #(.N_REQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_grant(logic [3:0] v, int p);
        int idx;
`ifdef ALU_ARB_RR_EN
        for (int k = 1; k <= 4; k++) begin
            idx = (p + k) % 4;
            if (v[idx[1:0]]) return idx;
        end
`else
        for (int i = 0; i < 4; i++) begin
            idx = i;
            if (v[idx[1:0]]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic int model_alu(int a, int b, int op);
        case (op)
            0:       return a + b;
            1:       return (a - b + 32) % 32;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic set_req(int i, int a, int b, int op);
        req_a[4*i +: 4]   = 4'(a);
        req_b[4*i +: 4]   = 4'(b);
        req_sel[2*i +: 2] = 2'(op);
    endtask

    // Advance one clock: sample req_ready mid-cycle, step the model, land 1ns after the edge
    task automatic tick();
        int g;
        int r;
        int a;
        int b;
        int op;
        @(negedge clk);
        seen_ready = req_ready;
        exp_ready  = '0;
        g = model_grant(req_valid, m_ptr);
        if (rst) begin
            m_valid = 1'b0; m_y = '0; m_cout = 1'b0; m_id = '0; m_ptr = 0;
        end else if ((!m_valid || rsp_ready) && g >= 0) begin
            a  = int'((req_a >> (4*g)) & 16'hF);
            b  = int'((req_b >> (4*g)) & 16'hF);
            op = int'((req_sel >> (2*g)) & 8'h3);
            r  = model_alu(a, b, op);
            exp_ready = 4'(1 << g);
            m_valid = 1'b1;
            m_y     = 4'(r % 16);
            m_cout  = (r >= 16);
            m_id    = 2'(g);
            m_ptr   = g;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
        tick();
        tick();
        total++;
        if (seen_ready !== 4'h0) begin
            bad++; $display("FAIL reset_ready got=%b want=0000", seen_ready);
        end
        total++;
        if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== 8'h00) begin
            bad++; $display("FAIL reset_outputs got=%b_%h_%b_%0d want=0_0_0_0", rsp_valid, rsp_y, rsp_cout, rsp_id);
        end
        rst = 1'b0; req_valid = 4'h0;
        tick();
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b1; req_valid = 4'b0100;
        set_req(2, 9, 8, 0);
        tick();
        total++;
        if (seen_ready !== 4'b0100) begin
            bad++; $display("FAIL add_ready got=%b want=0100", seen_ready);
        end
        total++;
        if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== {1'b1, 4'd1, 1'b1, 2'd2}) begin
            bad++; $display("FAIL add_result got=%b_%0d_%b_%0d want=1_1_1_2", rsp_valid, rsp_y, rsp_cout, rsp_id);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_sub_and_or();
        rsp_ready = 1'b1; req_valid = 4'b1000;
        set_req(3, 5, 3, 1);
        tick();
        total++;
        if ({rsp_y, rsp_cout} !== {4'd2, 1'b0}) begin
            bad++; $display("FAIL sub_noborrow got=%0d_%b want=2_0", rsp_y, rsp_cout);
        end
        set_req(3, 12, 10, 2);
        tick();
        total++;
        if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== {1'b1, 4'd8, 1'b0, 2'd3}) begin
            bad++; $display("FAIL and_result got=%b_%0d_%b_%0d want=1_8_0_3", rsp_valid, rsp_y, rsp_cout, rsp_id);
        end
        set_req(3, 12, 10, 3);
        tick();
        total++;
        if ({rsp_y, rsp_cout} !== {4'd14, 1'b0}) begin
            bad++; $display("FAIL or_result got=%0d_%b want=14_0", rsp_y, rsp_cout);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_back_to_back();
        int seq [5];
`ifdef ALU_ARB_RR_EN
        seq = '{0, 1, 2, 3, 0};
`else
        seq = '{0, 0, 0, 0, 0};
`endif
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, i + 1, i, 0);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (seen_ready !== 4'(1 << seq[c])) begin
                bad++; $display("FAIL fair_ready[%0d] got=%b want=%b", c, seen_ready, 4'(1 << seq[c]));
            end
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(seq[c])) begin
                bad++; $display("FAIL fair_id[%0d] got=%b_%0d want=1_%0d", c, rsp_valid, rsp_id, seq[c]);
            end
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b1; req_valid = 4'b0010;
        set_req(1, 3, 5, 1);
        tick();
        total++;
        if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== {1'b1, 4'd14, 1'b1, 2'd1}) begin
            bad++; $display("FAIL sub_borrow got=%b_%0d_%b_%0d want=1_14_1_1", rsp_valid, rsp_y, rsp_cout, rsp_id);
        end
        rsp_ready = 1'b0; req_valid = 4'b0001;
        set_req(0, 7, 7, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (seen_ready !== 4'h0) begin
                bad++; $display("FAIL bp_ready[%0d] got=%b want=0000", c, seen_ready);
            end
            total++;
            if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== {1'b1, 4'd14, 1'b1, 2'd1}) begin
                bad++; $display("FAIL bp_hold[%0d] got=%b_%0d_%b_%0d want=1_14_1_1", c, rsp_valid, rsp_y, rsp_cout, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if (seen_ready !== 4'b0001) begin
            bad++; $display("FAIL bp_release_ready got=%b want=0001", seen_ready);
        end
        total++;
        if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== {1'b1, 4'd14, 1'b0, 2'd0}) begin
            bad++; $display("FAIL bp_release_result got=%b_%0d_%b_%0d want=1_14_0_0", rsp_valid, rsp_y, rsp_cout, rsp_id);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        int want_id;
`ifdef ALU_ARB_RR_EN
        want_id = 1;
`else
        want_id = 0;
`endif
        rsp_ready = 1'b0; req_valid = 4'b0100;
        set_req(2, 1, 1, 0);
        tick();
        rst = 1'b1; req_valid = 4'b0011;
        set_req(0, 2, 2, 0);
        set_req(1, 4, 4, 0);
        tick();
        total++;
        if (seen_ready !== 4'h0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid got=%b_%b want=0000_0", seen_ready, rsp_valid);
        end
        rst = 1'b0; rsp_ready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'(want_id)) begin
            bad++; $display("FAIL rst_first_grant got=%b_%0d want=1_%0d", rsp_valid, rsp_id, want_id);
        end
        req_valid = 4'h0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            req_sel   = 8'($urandom);
            tick();
            total++;
            if (seen_ready !== exp_ready) begin
                bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", c, seen_ready, exp_ready);
            end
            total++;
            if ({rsp_valid, rsp_y, rsp_cout, rsp_id} !== {m_valid, m_y, m_cout, m_id}) begin
                bad++; $display("FAIL rand_out[%0d] got=%b_%0d_%b_%0d want=%b_%0d_%b_%0d", c,
                    rsp_valid, rsp_y, rsp_cout, rsp_id, m_valid, m_y, m_cout, m_id);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        m_valid = 1'b0; m_y = '0; m_cout = 1'b0; m_id = '0; m_ptr = 0;
        exp_ready = '0; seen_ready = '0;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sel = '0;
        test_reset();
        test_single_add();
        test_sub_and_or();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
